seq_match_controller: RTL and testbench
=======================================

// Module: seq_match_controller
// PURPOSE
//   Run-time controller for serial bit-pattern detection. It accepts a configuration:
//   pattern, length, overlap mode, target match count and observation window.
//   It then sequences a capture run over a qualified serial stream, counting Mealy
//   matches, and signals completion or timeout. It sits between the control path and
//   the serial input, generalising the fixed-pattern detectors to a programmable one.
// PARAMETERS
//   PAT_W  5   maximum pattern length in bits (>=2)
//   CNT_W  8   width of match counter and target
//   WIN_W  12  width of observation-window counter
// PORTS
//   clock        in   1      single system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   cfg_valid    in   1      configuration/start request
//   cfg_ready    out  1      high only in IDLE; cfg accepted when cfg_valid&&cfg_ready
//   cfg_pattern  in   PAT_W  pattern; bit [cfg_len-1] received first, bit [0] last
//   cfg_len      in   3      active pattern length, 1..PAT_W (0 treated as 1)
//   cfg_overlap  in   1      1 = overlapping matches allowed
//   cfg_target   in   CNT_W  matches needed for success; 0 = window-only run
//   cfg_window   in   WIN_W  max valid bits observed; 0 = unlimited
//   abort        in   1      cancel run, return to IDLE
//   datain       in   1      serial data bit
//   din_valid    in   1      datain qualifier; bits sampled only when high
//   busy         out  1      high in RUN
//   match        out  1      Mealy pulse: RUN && din_valid && hit, same cycle as last bit
//   match_count  out  CNT_W  matches in current/last run, saturating
//   done         out  1      one-cycle pulse on run completion (success or timeout)
//   timeout      out  1      last run ended by window expiry; held until next start
// BEHAVIOUR
//   Reset: state=IDLE; hist=0, fill=0, bit_cnt=0, match_count=0; timeout=0, done=0, busy=0.
//   FSM IDLE -> RUN on accepted cfg: latch cfg_*; clear hist, fill, bit_cnt,
//     match_count, timeout.
//   RUN, each din_valid cycle: cand={hist[PAT_W-2:0],datain};
//     mask = low cfg_len bits.
//     hit = (fill+1 >= len) && ((cand & mask) == (pattern & mask)).
//   On hit: match_count+1 (saturates at all-ones).
//     overlap=1: hist<=cand, fill<=min(fill+1,PAT_W).
//     overlap=0: hist<=0, fill<=0.
//   On no hit: hist<=cand, fill<=min(fill+1,PAT_W).
//   bit_cnt increments per valid bit; din_valid=0 cycles change nothing.
//   Success: target!=0 and the hit makes count==target. -> DONE, timeout=0.
//   Window expiry: window!=0 and bit_cnt+1==window on a valid bit, no success.
//     -> DONE, timeout=1.
//   Same bit gives success and expiry: success wins, timeout=0.
//   DONE: done=1 for exactly one cycle, then IDLE. match_count and timeout are held.
//   abort in RUN: -> IDLE next cycle; no done pulse; match_count holds the partial
//     value; timeout=0. abort is ignored in IDLE.
//   abort also suppresses match and the counter update that cycle.
//   cfg_valid outside IDLE is ignored (cfg_ready=0). No back-to-back start in the
//     DONE cycle.
//   reset mid-run: synchronous return to reset values; next cycle is IDLE.
//   cfg_len>PAT_W: clamp to PAT_W.
// STRUCTURE
//   Shared package seq_match_pkg: state encodings IDLE/RUN/DONE (2-bit),
//     PAT_W/CNT_W/WIN_W defaults.
//   Sub-module seq_pattern_matcher: hist/fill register, masked compare, combinational
//     hit, overlap clear.
//   Top-level owns the FSM, the window and match counters, and the cfg latch.
// TESTING
//   1 pat=11101 len5 ovl=1 tgt=0 win=9, stream 111011101
//     -> match on bits 5 and 9, count=2, done, timeout=1.
//   2 same, ovl=0 -> single match at bit 5, count=1, timeout=1 at bit 9.
//   3 pat=11 len2 ovl=1 tgt=3 win=0, stream 1111
//     -> matches bits 2,3,4, done in bit-4 cycle+1, timeout=0.
//   4 tgt=1 win=5, match lands on bit 5 -> success, timeout=0 (simultaneous case).
//   5 abort during RUN after 1 match -> IDLE, no done, count=1, cfg_ready=1 next cycle.
//   6 din_valid gaps inside pattern plus reset mid-run -> gaps ignored;
//     reset clears all outputs.

Source files
------------

// File: rtl/seq_match_pkg.sv
// Shared types and default widths for the programmable serial pattern matcher.
package seq_match_pkg;
    localparam int PAT_W_DEF = 5;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_pattern_matcher.sv
// Shift history of received bits with masked compare against the programmed pattern.
import seq_match_pkg::*;

module seq_pattern_matcher #(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic             datain_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [2:0]       len_i,
    input  logic             overlap_i,
    output logic             hit_o
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] cand, mask;
    logic [FW:0]      fill_p1;
    logic [FW-1:0]    fill_sat;

    assign cand    = {hist_q, datain_i};
    assign fill_p1 = {1'b0, fill_q} + (FW+1)'(1);
    assign fill_sat = (fill_q == FW'(PAT_W)) ? fill_q : fill_p1[FW-1:0];

    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_i));
        end
    end

    assign hit_o = (fill_p1 >= (FW+1)'(len_i)) && ((cand & mask) == (pattern_i & mask));

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (step_i) begin
            // Non-overlap mode restarts the history so the next match needs fresh bits
            if (hit_o && !overlap_i) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = cand[PAT_W-2:0];
                fill_d = fill_sat;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/seq_match_controller.sv
// Run controller: latches a configuration, counts matches over a window, reports done/timeout.
import seq_match_pkg::*;

module seq_match_controller #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic [2:0]       cfg_len_i,
    input  logic             cfg_overlap_i,
    input  logic [CNT_W-1:0] cfg_target_i,
    input  logic [WIN_W-1:0] cfg_window_i,
    input  logic             abort_i,
    input  logic             datain_i,
    input  logic             din_valid_i,
    output logic             busy_o,
    output logic             match_o,
    output logic [CNT_W-1:0] match_count_o,
    output logic             done_o,
    output logic             timeout_o
);
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [2:0]       len_q, len_d, len_eff;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_q, timeout_d;
    logic             start, step, hit, success, expire;

    assign start   = (state_q == IDLE) && cfg_valid_i;
    // abort masks the sample entirely, so neither matcher nor counters advance
    assign step    = (state_q == RUN) && din_valid_i && !abort_i;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign success = step && hit && (tgt_q != '0) && (cnt_inc == tgt_q);
    assign expire  = step && (win_q != '0) && ((bit_cnt_q + WIN_W'(1)) == win_q);

    always_comb begin
        len_eff = cfg_len_i;
        if (cfg_len_i == 3'd0)              len_eff = 3'd1;
        else if (int'(cfg_len_i) > PAT_W)   len_eff = 3'(PAT_W);
    end

    seq_pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (start),
        .step_i    (step),
        .datain_i  (datain_i),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .overlap_i (ovl_q),
        .hit_o     (hit)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;
        win_d     = win_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    state_d   = RUN;
                    pat_d     = cfg_pattern_i;
                    len_d     = len_eff;
                    ovl_d     = cfg_overlap_i;
                    tgt_d     = cfg_target_i;
                    win_d     = cfg_window_i;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    timeout_d = 1'b0;
                end else if (step) begin
                    bit_cnt_d = bit_cnt_q + WIN_W'(1);
                    if (hit) cnt_d = cnt_inc;
                    if (success) begin
                        state_d   = DONE;
                        timeout_d = 1'b0;
                    end else if (expire) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= 3'd1;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            win_q     <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            win_q     <= win_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign cfg_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == DONE);
    assign match_o       = step && hit;
    assign match_count_o = cnt_q;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_seq_match_controller.sv
// Directed and random checks of seq_match_controller against a bit-list reference model.
module tb_seq_match_controller;
    logic        clk = 1'b0;
    logic        rst, cfg_valid, cfg_ready, ovl, ab, din, dv;
    logic [4:0]  pat;
    logic [2:0]  len;
    logic [7:0]  tgt;
    logic [11:0] win;
    logic        busy, match, done, timeout;
    logic [7:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit       m_run, m_done, m_to, m_ovl;
    int       m_cnt, m_bcnt, m_len, m_tgt, m_win;
    bit [4:0] m_pat;
    bit       m_bits[$];

    always #5 clk = ~clk;

    seq_match_controller dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_pattern_i (pat),
        .cfg_len_i     (len),
        .cfg_overlap_i (ovl),
        .cfg_target_i  (tgt),
        .cfg_window_i  (win),
        .abort_i       (ab),
        .datain_i      (din),
        .din_valid_i   (dv),
        .busy_o        (busy),
        .match_o       (match),
        .match_count_o (count),
        .done_o        (done),
        .timeout_o     (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hit when the last len received bits (since start or last non-overlap match) spell the pattern
    function automatic bit model_hit(input bit d);
        bit q[$];
        q = m_bits;
        q.push_back(d);
        if (q.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (q[q.size() - m_len + i] != m_pat[m_len-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit cv, input bit a, input bit v, input bit d);
        bit h, succ, exp_;
        if (r) begin
            m_run = 0; m_done = 0; m_to = 0; m_cnt = 0; m_bcnt = 0; m_bits.delete();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (cv) begin
                m_run = 1; m_pat = pat; m_ovl = ovl; m_tgt = tgt; m_win = win;
                m_len = (len == 0) ? 1 : (len > 5) ? 5 : int'(len);
                m_cnt = 0; m_bcnt = 0; m_to = 0; m_bits.delete();
            end
        end else if (a) begin
            m_run = 0; m_to = 0;
        end else if (v) begin
            h = model_hit(d);
            m_bcnt++;
            m_bits.push_back(d);
            if (m_bits.size() > 8) void'(m_bits.pop_front());
            if (h) begin
                if (m_cnt < 255) m_cnt++;
                if (!m_ovl) m_bits.delete();
            end
            succ = (m_tgt != 0) && h && (m_cnt == m_tgt);
            exp_ = (m_win != 0) && (m_bcnt == m_win);
            if (succ) begin
                m_run = 0; m_done = 1; m_to = 0;
            end else if (exp_) begin
                m_run = 0; m_done = 1; m_to = 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit cv, input bit a, input bit v, input bit d);
        bit em;
        @(negedge clk);
        rst = r; cfg_valid = cv; ab = a; dv = v; din = d;
        #1;
        if (!r) begin
            em = m_run && v && !a && model_hit(d);
            chk("match", match, em);
            chk("cfg_ready_pre", cfg_ready, !m_run && !m_done);
        end
        model_edge(r, cv, a, v, d);
        @(posedge clk);
        #1;
        chk("count", count, m_cnt);
        chk("timeout", timeout, m_to);
        chk("done", done, m_done);
        chk("busy", busy, m_run);
        chk("cfg_ready", cfg_ready, !m_run && !m_done);
        rst = 0; cfg_valid = 0; ab = 0; dv = 0; din = 0;
    endtask

    task automatic start_run(input bit [4:0] p, input bit [2:0] l, input bit o,
                             input bit [7:0] t, input bit [11:0] w);
        pat = p; len = l; ovl = o; tgt = t; win = w;
        cycle(0, 1, 0, 0, 0);
    endtask

    task automatic send(input bit [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(0, 0, 0, 1, s[i]);
    endtask

    int nmatch;
    always @(negedge clk) if (match === 1'b1) nmatch++;

    initial begin
        rst = 1; cfg_valid = 0; ab = 0; dv = 0; din = 0;
        pat = 0; len = 0; ovl = 0; tgt = 0; win = 0;
        cycle(1, 0, 0, 0, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);

        // 1: overlapping, window-only, timeout after 9 bits
        nmatch = 0;
        start_run(5'b11101, 3'd5, 1, 8'd0, 12'd9);
        send(16'b111011101, 9);
        chk("t1_done", done, 1);
        chk("t1_count", count, 2);
        chk("t1_timeout", timeout, 1);
        chk("t1_nmatch", nmatch, 2);
        cycle(0, 1, 0, 0, 0);  // start request during DONE is ignored
        chk("t1_idle", cfg_ready, 1);
        chk("t1_hold_to", timeout, 1);

        // 2: same without overlap
        nmatch = 0;
        start_run(5'b11101, 3'd5, 0, 8'd0, 12'd9);
        chk("t2_to_clear", timeout, 0);
        send(16'b111011101, 9);
        chk("t2_count", count, 1);
        chk("t2_timeout", timeout, 1);
        chk("t2_nmatch", nmatch, 1);
        cycle(0, 0, 0, 0, 0);

        // 3: target reached
        start_run(5'b00011, 3'd2, 1, 8'd3, 12'd0);
        send(16'b1111, 4);
        chk("t3_done", done, 1);
        chk("t3_count", count, 3);
        chk("t3_timeout", timeout, 0);
        cycle(0, 0, 0, 0, 0);

        // 4: success and expiry on the same bit
        start_run(5'b11101, 3'd5, 1, 8'd1, 12'd5);
        send(16'b11101, 5);
        chk("t4_done", done, 1);
        chk("t4_timeout", timeout, 0);
        cycle(0, 0, 0, 0, 0);

        // 5: abort after one match, abort also masks a would-be hit
        start_run(5'b00011, 3'd2, 1, 8'd0, 12'd0);
        send(16'b11, 2);
        cycle(0, 0, 1, 1, 1);
        chk("t5_count", count, 1);
        chk("t5_ready", cfg_ready, 1);
        chk("t5_done", done, 0);

        // 6: din_valid gaps inside the pattern, then reset mid-run
        start_run(5'b00101, 3'd3, 1, 8'd0, 12'd0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 1);
        chk("t6_count", count, 1);
        cycle(1, 0, 0, 1, 1);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", cfg_ready, 1);

        // random runs; len 0 and >5 exercise the clamp
        for (int r = 0; r < 60; r++) begin
            start_run(5'($urandom), 3'($urandom), 1'($urandom), 8'($urandom_range(0, 4)),
                      12'($urandom_range(0, 24)));
            for (int k = 0; k < 40 && (m_run || m_done); k++)
                cycle(($urandom_range(0, 200) == 0), 1'($urandom), ($urandom_range(0, 50) == 0),
                      ($urandom_range(0, 3) != 0), 1'($urandom));
            if (m_run) cycle(0, 0, 1, 0, 0);
            if (m_done) cycle(0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
